// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared types and constants for the MEM->WB pipeline register
package mem_wb_pkg;

  localparam int DEPTH_MAX          = 4;
  localparam int REG_ZERO           = 0;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;

  // Canonical payload layout at default widths; the top mirrors this field order
  // at its own parameterised widths so both pack identically.
  typedef struct packed {
    logic                          reg_write;
    logic                          memtoreg;
    logic [DEF_DATA_WIDTH-1:0]     alu_result;
    logic [DEF_DATA_WIDTH-1:0]     read_data;
    logic [DEF_REG_ADDR_WIDTH-1:0] write_reg;
  } mem_wb_payload_t;

  // Packed payload width for a given datapath / register-address width.
  function automatic int payload_width(input int dw, input int aw);
    return 2 + 2 * dw + aw;
  endfunction

endpackage

// File: rtl/mem_wb_slot.sv
// rtl/mem_wb_slot.sv - one valid/ready pipeline slot (valid bit plus payload)
module mem_wb_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A slot can take a new beat when empty or when its contents move on this cycle.
  assign ready_o = !valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Next state: flush empties the slot; payload only captured from a valid beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - DEPTH-stage MEM->WB pipeline register; MEM_WB_FWD_EN adds forwarding outputs
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_reg_write,
  input  logic                      in_memtoreg,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [DATA_WIDTH-1:0]     in_read_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_write_reg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      mux3_sel,
  output logic [CNT_WIDTH-1:0]      retire_count
`ifdef MEM_WB_FWD_EN
  ,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("mem_wb_pipe: DEPTH must be in 1..%0d", DEPTH_MAX);
  end

  typedef struct packed {
    logic                      reg_write;
    logic                      memtoreg;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     read_data;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
  } payload_t;

  localparam int PW = payload_width(DATA_WIDTH, REG_ADDR_WIDTH);

  // Index 0 is the upstream input; index k+1 is the output of stage k.
  logic [DEPTH:0] valid;
  logic [DEPTH:0] ready;
  payload_t       pl [DEPTH+1];
  payload_t       last_pl;
  logic           fire;
  logic [CNT_WIDTH-1:0] retire_q, retire_d;

  assign valid[0]     = in_valid;
  assign pl[0]        = '{reg_write:  in_reg_write,
                          memtoreg:   in_memtoreg,
                          alu_result: in_alu_result,
                          read_data:  in_read_data,
                          write_reg:  in_write_reg};
  assign ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    mem_wb_slot #(.W(PW)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .valid_i (valid[k]),
      .data_i  (pl[k]),
      .ready_o (ready[k]),
      .valid_o (valid[k+1]),
      .data_o  (pl[k+1]),
      .ready_i (ready[k+1])
    );
  end

  assign last_pl   = pl[DEPTH];
  assign out_valid = valid[DEPTH];
  // During flush the incoming beat is discarded anyway, so upstream never stalls.
  assign in_ready  = ready[0] | flush;
  assign fire      = out_valid & out_ready;
  assign rf_we     = fire & last_pl.reg_write
                   & (last_pl.write_reg != REG_ADDR_WIDTH'(REG_ZERO));
  assign rf_waddr  = last_pl.write_reg;
  assign rf_wdata  = last_pl.memtoreg ? last_pl.read_data : last_pl.alu_result;
  assign mux3_sel  = last_pl.memtoreg;
  assign retire_count = retire_q;

  // Every consumed entry retires, including $0 and non-writing ones.
  always_comb begin
    retire_d = retire_q;
    if (fire) retire_d = retire_q + CNT_WIDTH'(1);
  end

  // Retire counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_q <= '0;
    else        retire_q <= retire_d;
  end

`ifdef MEM_WB_FWD_EN
  // Youngest writing stage wins: scan oldest to youngest so stage 0 overrides last.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid[k] && pl[k].reg_write &&
          (pl[k].write_reg != REG_ADDR_WIDTH'(REG_ZERO))) begin
        fwd_valid = 1'b1;
        fwd_addr  = pl[k].write_reg;
        fwd_data  = pl[k].memtoreg ? pl[k].read_data : pl[k].alu_result;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - self-checking bench for mem_wb_pipe at DEPTH=2 and DEPTH=3
module tb_mem_wb_pipe;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    int          cyc;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_rw, in_mtr, out_ready;
  logic [31:0] in_alu, in_rd;
  logic [4:0]  in_wr;

  logic        ir [2];
  logic        ov [2];
  logic        we [2];
  logic        ms [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [31:0] rc [2];

  mem_wb_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DEPTH(2), .CNT_WIDTH(32)) u_dut_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_reg_write(in_rw), .in_memtoreg(in_mtr), .in_alu_result(in_alu),
    .in_read_data(in_rd), .in_write_reg(in_wr), .out_valid(ov[0]), .out_ready(out_ready),
    .rf_we(we[0]), .rf_waddr(wa[0]), .rf_wdata(wd[0]), .mux3_sel(ms[0]),
    .retire_count(rc[0])
  );

  mem_wb_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DEPTH(3), .CNT_WIDTH(32)) u_dut_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_reg_write(in_rw), .in_memtoreg(in_mtr), .in_alu_result(in_alu),
    .in_read_data(in_rd), .in_write_reg(in_wr), .out_valid(ov[1]), .out_ready(out_ready),
    .rf_we(we[1]), .rf_waddr(wa[1]), .rf_wdata(wd[1]), .mux3_sel(ms[1]),
    .retire_count(rc[1])
  );

  // Reference: each pipe is an in-order FIFO of accepted beats holding at most DEPTH.
  ent_t        mq [2][$];
  int unsigned mcnt [2];
  int          cyc;
  bit          lat_chk;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("d%0d_%s", (d == 0) ? 2 : 3, s);
  endfunction

  task automatic drive(input bit v, input bit rw, input bit mtr, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [4:0] wr, input bit ordy,
                       input bit fl);
    in_valid = v; in_rw = rw; in_mtr = mtr; in_alu = alu; in_rd = rd; in_wr = wr;
    out_ready = ordy; flush = fl;
  endtask

  // Check the cycle's combinational outputs against the model, advance the model,
  // then move to the next falling edge.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      int   depth;
      bit   qe;
      bit   fire_m;
      logic exp_ir;
      depth  = (d == 0) ? 2 : 3;
      qe     = (mq[d].size() == 0);
      exp_ir = flush | out_ready | (mq[d].size() < depth);
      check(tg(d, "in_ready"), ir[d], exp_ir);
      check(tg(d, "retire_count"), rc[d], mcnt[d]);
      if (qe) check(tg(d, "out_valid_empty"), ov[d], 0);
      fire_m = ov[d] & out_ready & !qe;
      if (ov[d] && !qe) begin
        ent_t e;
        e = mq[d][0];
        check(tg(d, "rf_waddr"), wa[d], e.wr);
        check(tg(d, "rf_wdata"), wd[d], e.mtr ? e.rd : e.alu);
        check(tg(d, "mux3_sel"), ms[d], e.mtr);
        check(tg(d, "rf_we"), we[d], e.rw && (e.wr != 0) && out_ready);
        if (lat_chk && out_ready) check(tg(d, "latency"), cyc - e.cyc, depth);
      end else begin
        check(tg(d, "rf_we_idle"), we[d], 0);
      end
      if (fire_m) begin
        void'(mq[d].pop_front());
        mcnt[d]++;
      end
      if (flush) mq[d].delete();
      else if (in_valid && ir[d]) mq[d].push_back('{in_rw, in_mtr, in_alu, in_rd, in_wr, cyc});
    end
    @(negedge clk);
    cyc++;
  endtask

  // Assert reset mid-cycle and check outputs clear without waiting for a clock edge.
  task automatic do_reset_mid();
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check(tg(d, "rst_out_valid"), ov[d], 0);
      check(tg(d, "rst_rf_we"), we[d], 0);
      check(tg(d, "rst_in_ready"), ir[d], 1);
      check(tg(d, "rst_retire"), rc[d], 0);
      check(tg(d, "rst_rf_wdata"), wd[d], 0);
      check(tg(d, "rst_rf_waddr"), wa[d], 0);
      check(tg(d, "rst_mux3_sel"), ms[d], 0);
      mq[d].delete();
      mcnt[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; lat_chk = 0;
    mcnt[0] = 0; mcnt[1] = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    do_reset_mid();

    // Three ALU results to r3..r5 with out_ready held high.
    lat_chk = 1;
    drive(1, 1, 0, 32'h10, $urandom, 5'd3, 1, 0); step();
    drive(1, 1, 0, 32'h11, $urandom, 5'd4, 1, 0); step();
    drive(1, 1, 0, 32'h12, $urandom, 5'd5, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) step();
    check("t2_retire_count", rc[0], 3);

    // Memory read data selected for writeback.
    drive(1, 1, 1, 32'h1234, 32'hDEADBEEF, 5'd7, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    #1;
    check("t3_rf_wdata", wd[0], 32'hDEADBEEF);
    check("t3_mux3_sel", ms[0], 1);
    repeat (3) step();

    // Write to $0 is suppressed but still retires.
    drive(1, 1, 0, 32'h55, 32'h66, 5'd0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) step();
    check("t4_retire_count", rc[0], 5);
    lat_chk = 0;

    // Backpressure: fill DEPTH=3, hold out_ready low for five cycles, then drain.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, i[0], 32'h100 + i, 32'h200 + i, 5'(8 + i), 0, 0); step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 32'hBAD, 32'hBAD, 5'd31, 0, 0);
      #1;
      check("t5_in_ready_full", ir[1], 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) step();

    // Flush with two entries in flight.
    drive(1, 1, 0, 32'hA0, 0, 5'd9, 1, 0);  step();
    drive(1, 1, 0, 32'hA1, 0, 5'd10, 1, 0); step();
    drive(1, 1, 0, 32'hA2, 0, 5'd11, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    check("t6_d2_out_valid", ov[0], 0);
    check("t6_d3_out_valid", ov[1], 0);
    check("t6_d3_in_ready", ir[1], 1);
    repeat (4) step();

    // Reset asserted mid-stream.
    drive(1, 1, 0, 32'hC0, 0, 5'd12, 1, 0); step();
    drive(1, 1, 0, 32'hC1, 0, 5'd13, 1, 0); step();
    do_reset_mid();

    // Randomised traffic with backpressure, flushes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] wr;
      wr = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      drive(($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom, $urandom, wr,
            ($urandom % 3) != 0, ($urandom % 20) == 0);
      if ($urandom % 150 == 0) do_reset_mid();
      else step();
    end

    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
